// File: rtl/sort_pkg.sv
// Shared definitions for the sorter: receiver state encoding and default geometry.
package sort_pkg;

  localparam int DEF_DWIDTH = 8;
  localparam int DEF_AWIDTH = 4;
  localparam int MAX_LEN    = 2 ** DEF_AWIDTH;

  typedef enum logic [1:0] {
    IDLE_S      = 2'd0,
    RECV_S      = 2'd1,
    HOLD_BUSY_S = 2'd2,
    WAIT_DONE_S = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sort_input_rx.sv
// Input-side packet receiver: stores a val/sop/eop stream into the sort RAM and
// raises the packet strobe whose falling edge kicks off the sorter.
module sort_input_rx
  import sort_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              val_i,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic              busy_i,
  output logic              ram_we_o,
  output logic [AWIDTH-1:0] ram_addr_o,
  output logic [DWIDTH-1:0] ram_data_o,
  output logic              pkt_wren_o,
  output logic [AWIDTH-1:0] cntr_o,
  output logic              err_o,
  output logic              drop_o
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = '1;

  rx_state_t         state;
  logic [AWIDTH-1:0] cntr;
  logic [DWIDTH-1:0] wdata;
  logic              we;
  logic              wren;
  logic              err;
  logic              drop;
  logic              sop_hit;

  assign sop_hit = val_i & sop_i;

  // The write address and the last-index count are one register, so they can never disagree.
  assign ram_addr_o = cntr;
  assign cntr_o     = cntr;
  assign ram_we_o   = we;
  assign ram_data_o = wdata;
  assign pkt_wren_o = wren;
  assign err_o      = err;
  assign drop_o     = drop;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE_S;
      cntr  <= '0;
      wdata <= '0;
      we    <= 1'b0;
      wren  <= 1'b0;
      err   <= 1'b0;
      drop  <= 1'b0;
    end else begin
      we   <= 1'b0;
      drop <= 1'b0;
      case (state)
        IDLE_S: begin
          if (sop_hit) begin
            we    <= 1'b1;
            wdata <= data_i;
            cntr  <= '0;
            err   <= 1'b0;
            wren  <= 1'b1;
            state <= eop_i ? HOLD_BUSY_S : RECV_S;
          end
        end
        RECV_S: begin
          if (val_i) begin
            if (sop_i) begin
              we    <= 1'b1;
              wdata <= data_i;
              cntr  <= '0;
              err   <= 1'b1;
              state <= eop_i ? HOLD_BUSY_S : RECV_S;
            end else begin
              // A full RAM discards the word without wrapping the address.
              if (cntr == LAST_ADDR) begin
                err <= 1'b1;
              end else begin
                we    <= 1'b1;
                wdata <= data_i;
                cntr  <= cntr + 1'b1;
              end
              if (eop_i) state <= HOLD_BUSY_S;
            end
          end
        end
        HOLD_BUSY_S: begin
          wren <= 1'b0;
          drop <= sop_hit;
          if (busy_i) state <= WAIT_DONE_S;
        end
        WAIT_DONE_S: begin
          drop <= sop_hit;
          if (!busy_i) state <= IDLE_S;
        end
        default: state <= IDLE_S;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_input_rx.sv
// Self-checking bench for sort_input_rx: directed packets with literal expectations,
// then randomized traffic compared every cycle against a packet-level model.
module tb_sort_input_rx;
  import sort_pkg::*;

  localparam int DW = DEF_DWIDTH;
  localparam int AW = DEF_AWIDTH;

  typedef logic [DW-1:0] word_q_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data = '0;
  logic          val = 1'b0;
  logic          sop = 1'b0;
  logic          eop = 1'b0;
  logic          busy = 1'b0;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          pkt_wren;
  logic [AW-1:0] cntr;
  logic          err;
  logic          drop;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sort_input_rx dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .data_i    (data),
    .val_i     (val),
    .sop_i     (sop),
    .eop_i     (eop),
    .busy_i    (busy),
    .ram_we_o  (ram_we),
    .ram_addr_o(ram_addr),
    .ram_data_o(ram_data),
    .pkt_wren_o(pkt_wren),
    .cntr_o    (cntr),
    .err_o     (err),
    .drop_o    (drop)
  );

  // Packet-level reference: a packet is either being received, waiting for the
  // sorter to start, waiting for it to finish, or nothing is happening.
  bit            m_rx = 0;
  bit            m_wait_start = 0;
  bit            m_wait_end = 0;
  int            m_nwords = 0;
  logic          e_we = 0;
  logic          e_wren = 0;
  logic          e_err = 0;
  logic          e_drop = 0;
  logic [AW-1:0] e_cntr = '0;
  logic [DW-1:0] e_data = '0;

  task automatic modelReset();
    m_rx = 0; m_wait_start = 0; m_wait_end = 0; m_nwords = 0;
    e_we = 0; e_wren = 0; e_err = 0; e_drop = 0; e_cntr = '0; e_data = '0;
  endtask

  task automatic modelStart(input logic [DW-1:0] d, input bit last);
    e_we = 1; e_cntr = '0; e_data = d; e_err = 0; e_wren = 1;
    m_nwords = 1;
    m_rx = !last;
    m_wait_start = last;
  endtask

  task automatic modelStep();
    bit            v, s, e, b;
    logic [DW-1:0] d;
    v = val; s = sop; e = eop; b = busy; d = data;
    e_we = 0;
    e_drop = 0;
    if (m_rx) begin
      if (v) begin
        if (s) begin
          modelStart(d, e);
          e_err = 1;
        end else begin
          if (m_nwords < MAX_LEN) begin
            e_we = 1;
            e_cntr = AW'(m_nwords);
            e_data = d;
            m_nwords++;
          end else begin
            e_err = 1;
          end
          if (e) begin
            m_rx = 0;
            m_wait_start = 1;
          end
        end
      end
    end else if (m_wait_start || m_wait_end) begin
      e_wren = 0;
      e_drop = v && s;
      if (m_wait_start) begin
        if (b) begin
          m_wait_start = 0;
          m_wait_end = 1;
        end
      end else if (!b) begin
        m_wait_end = 0;
      end
    end else if (v && s) begin
      modelStart(d, e);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) modelReset();
    else modelStep();
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Logs of what the DUT did, used by the directed literal checks.
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  int            wr_cyc[$];
  int            wren_len = 0;
  int            drop_cnt = 0;
  int            cyc = 0;
  logic [AW-1:0] cntr_at_fall = '0;
  logic          log_prev_wren = 0;

  initial forever begin
    @(negedge clk);
    checkOutput("ram_we", ram_we, e_we);
    checkOutput("pkt_wren", pkt_wren, e_wren);
    checkOutput("cntr", cntr, e_cntr);
    checkOutput("ram_addr", ram_addr, e_cntr);
    checkOutput("err", err, e_err);
    checkOutput("drop", drop, e_drop);
    if (e_we) checkOutput("ram_data", ram_data, e_data);
    if (ram_we) begin
      wr_addr.push_back(ram_addr);
      wr_data.push_back(ram_data);
      wr_cyc.push_back(cyc);
    end
    if (pkt_wren) wren_len++;
    if (log_prev_wren && !pkt_wren) cntr_at_fall = cntr;
    if (drop) drop_cnt++;
    log_prev_wren = pkt_wren;
    cyc++;
  end

  task automatic clearLogs();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    wren_len = 0;
    drop_cnt = 0;
  endtask

  // Sorter stand-in: raises busy two cycles after the strobe falls.
  bit auto_busy = 0;
  int busy_len = 10;
  int bt_dly = 0;
  int bt_left = 0;
  bit bt_prev = 0;

  task automatic busyTick();
    if (auto_busy) begin
      if (bt_prev && !pkt_wren) begin
        bt_dly = 2;
      end else if (bt_dly > 0) begin
        bt_dly--;
        if (bt_dly == 0) begin
          busy = 1;
          bt_left = busy_len;
        end
      end else if (bt_left > 0) begin
        bt_left--;
        if (bt_left == 0) busy = 0;
      end
    end
    bt_prev = pkt_wren;
  endtask

  task automatic applyStimulus(input bit v, input bit s, input bit e, input logic [DW-1:0] d);
    busyTick();
    val = v; sop = s; eop = e; data = d;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, '0);
  endtask

  task automatic sendPacket(input word_q_t words, input int gap_at, input int gap_len);
    for (int i = 0; i < words.size(); i++) begin
      if (i == gap_at) idle(gap_len);
      applyStimulus(1, i == 0, i == words.size() - 1, words[i]);
    end
  endtask

  word_q_t pkt;

  initial begin
    rst_n = 0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_ram_we", ram_we, 0);
    checkOutput("rst_pkt_wren", pkt_wren, 0);
    checkOutput("rst_cntr", cntr, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_drop", drop, 0);
    rst_n = 1;
    auto_busy = 1;
    busy_len = 10;
    idle(2);

    // 5-word packet without gaps
    clearLogs();
    pkt = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5};
    sendPacket(pkt, -1, 0);
    idle(20);
    checkOutput("t1_nwrites", wr_addr.size(), 5);
    for (int i = 0; i < wr_addr.size(); i++) begin
      checkOutput("t1_addr", wr_addr[i], i);
      checkOutput("t1_data", wr_data[i], pkt[i]);
    end
    if (wr_cyc.size() == 5) checkOutput("t1_consecutive", wr_cyc[4] - wr_cyc[0], 4);
    checkOutput("t1_wren_len", wren_len, 5);
    checkOutput("t1_cntr_fall", cntr_at_fall, 4);
    checkOutput("t1_err", err, 0);

    // single-word packet
    clearLogs();
    applyStimulus(1, 1, 1, 8'hA5);
    idle(20);
    checkOutput("t2_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() > 0) checkOutput("t2_addr", wr_addr[0], 0);
    checkOutput("t2_wren_len", wren_len, 1);
    checkOutput("t2_cntr_fall", cntr_at_fall, 0);

    // 20-word overflow packet
    clearLogs();
    pkt.delete();
    for (int i = 0; i < 20; i++) pkt.push_back(DW'(i + 16));
    sendPacket(pkt, -1, 0);
    idle(20);
    checkOutput("t3_nwrites", wr_addr.size(), 16);
    if (wr_addr.size() > 0) checkOutput("t3_last_addr", wr_addr[wr_addr.size()-1], 15);
    checkOutput("t3_err", err, 1);
    checkOutput("t3_cntr_fall", cntr_at_fall, 15);
    checkOutput("t3_wren_len", wren_len, 20);

    // 4-word packet with a 2-cycle gap between words 1 and 2
    clearLogs();
    pkt = '{8'h10, 8'h20, 8'h30, 8'h40};
    sendPacket(pkt, 2, 2);
    idle(20);
    checkOutput("t4_nwrites", wr_addr.size(), 4);
    for (int i = 0; i < wr_addr.size(); i++) checkOutput("t4_addr", wr_addr[i], i);
    checkOutput("t4_wren_len", wren_len, 6);
    checkOutput("t4_cntr_fall", cntr_at_fall, 3);
    checkOutput("t4_err", err, 0);

    // busy handled by hand: sop during busy is dropped, sop right after busy is taken
    auto_busy = 0;
    busy = 0;
    pkt = '{8'h07, 8'h09};
    sendPacket(pkt, -1, 0);
    idle(2);
    busy = 1;
    clearLogs();
    idle(2);
    pkt = '{8'h01, 8'h02, 8'h03};
    sendPacket(pkt, -1, 0);
    idle(5);
    busy = 0;
    idle(1);
    applyStimulus(1, 1, 1, 8'h42);
    bt_dly = 0;
    bt_left = 0;
    auto_busy = 1;
    idle(20);
    checkOutput("t5_drop_cnt", drop_cnt, 1);
    checkOutput("t5_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() > 0) begin
      checkOutput("t5_addr", wr_addr[0], 0);
      checkOutput("t5_data", wr_data[0], 8'h42);
    end

    // reset in the middle of a packet
    applyStimulus(1, 1, 0, 8'hD0);
    applyStimulus(1, 0, 0, 8'hD1);
    applyStimulus(1, 0, 0, 8'hD2);
    #1;
    rst_n = 0;
    #1;
    checkOutput("t6_ram_we", ram_we, 0);
    checkOutput("t6_pkt_wren", pkt_wren, 0);
    checkOutput("t6_cntr", cntr, 0);
    checkOutput("t6_ram_data", ram_data, 0);
    checkOutput("t6_err", err, 0);
    @(posedge clk);
    #2;
    rst_n = 1;
    busy = 0; bt_dly = 0; bt_left = 0;
    clearLogs();
    pkt = '{8'h55, 8'h66};
    sendPacket(pkt, -1, 0);
    idle(20);
    checkOutput("t6_nwrites", wr_addr.size(), 2);
    if (wr_addr.size() > 0) checkOutput("t6_first_addr", wr_addr[0], 0);
    checkOutput("t6_wren_len", wren_len, 2);

    // randomized traffic: gaps, restarts, stray words and packets arriving during busy
    for (int p = 0; p < 150; p++) begin
      int len;
      busy_len = $urandom_range(1, 12);
      len = $urandom_range(1, 20);
      if ($urandom_range(0, 7) == 0) applyStimulus(1, 0, $urandom_range(0, 1) == 1, DW'($urandom));
      for (int i = 0; i < len; i++) begin
        bit s;
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
        s = (i == 0) || ($urandom_range(0, 15) == 0);
        applyStimulus(1, s, i == len - 1, DW'($urandom));
      end
      idle($urandom_range(0, 25));
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
